d_frame_rx: RTL and testbench

- Receiving end of the blockC→blockD dSt stream. Accepts single dT items (D_SIZE = 3 bits) over a valid/ready handshake and packs C_ANOTHER_SIZE (10) consecutive items into one 30-bit frame.
- Presents each frame on a registered valid/ready output toward the blockD datapath.
- Owns a 4-bit cStateT state register, exported for debug.

---
 rtl/d_frame_rx.sv | 95 +++++++++
 tb/tb_d_frame_rx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/d_frame_rx.sv
// d_frame_rx: packs FRAME_LEN consecutive D_W-bit items into one frame behind valid/ready handshakes.
// Define D_FRAME_RX_TIMEOUT_EN to drop a partial frame after TIMEOUT_CYCLES idle cycles.
module d_frame_rx #(
   parameter int FRAME_LEN      = 10,
   parameter int D_W            = 3,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     d_valid,
   input  logic [D_W-1:0]           d_data,
   output logic                     d_ready,
   output logic                     frame_valid,
   output logic [FRAME_LEN*D_W-1:0] frame_data,
   input  logic                     frame_ready,
   output logic [3:0]               state,
   output logic                     drop_pulse
);
   typedef enum logic [3:0] {IDLE = 4'h0, COLLECT = 4'h1, FULL = 4'h2} state_t;
   localparam logic [3:0] LAST = 4'(FRAME_LEN - 1);
   if (FRAME_LEN < 2 || FRAME_LEN > 15 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 31) begin : g_bad_param
      $error("d_frame_rx: parameter out of range");
   end
   // raw bits rather than state_t so illegal encodings stay representable and recoverable
   logic [3:0]               state_q;
   logic [3:0]               cnt_q;
   logic [3:0]               slot;
   logic [FRAME_LEN*D_W-1:0] frame_q;
   logic                     valid_q;
   logic                     drop_q;
   logic                     acc;
   logic                     timeout;
   assign d_ready     = (state_q == IDLE || state_q == COLLECT) ? 1'b1 : (state_q == FULL) ? frame_ready : 1'b0;
   assign acc         = d_valid && d_ready;
   assign slot        = (state_q == COLLECT && !timeout) ? cnt_q : 4'd0;
   assign frame_valid = valid_q;
   assign frame_data  = frame_q;
   assign state       = state_q;
   assign drop_pulse  = drop_q;
`ifdef D_FRAME_RX_TIMEOUT_EN
   localparam logic [4:0] TO = 5'(TIMEOUT_CYCLES);
   logic [4:0] idle_q;
   assign timeout = state_q == COLLECT && idle_q == TO;
   always_ff @(posedge clk) begin
      if (rst) idle_q <= '0;
      else idle_q <= (state_q != COLLECT || acc || timeout) ? 5'd0 : idle_q + 5'd1;
   end
`else
   assign timeout = 1'b0;
`endif
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         frame_q <= '0;
         valid_q <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         drop_q <= timeout;
         case (state_q)
            IDLE, COLLECT: begin
               if (acc) frame_q[slot*D_W +: D_W] <= d_data;
               if (acc && slot == LAST) begin
                  state_q <= FULL;
                  valid_q <= 1'b1;
                  cnt_q   <= '0;
               end else if (acc) begin
                  state_q <= COLLECT;
                  cnt_q   <= slot + 4'd1;
               end else if (timeout) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end
            end
            FULL: begin
               if (frame_ready) begin
                  valid_q <= 1'b0;
                  if (d_valid) begin
                     frame_q[D_W-1:0] <= d_data;
                     cnt_q            <= 4'd1;
                     state_q          <= COLLECT;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: begin
               state_q <= IDLE;
               cnt_q   <= '0;
               valid_q <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_d_frame_rx.sv
// tb_d_frame_rx: randomized and directed stimulus against an item-list reference model with a frame scoreboard.
module tb_d_frame_rx;
   localparam int FL = 10;
   localparam int DW = 3;
   localparam int TO = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic d_valid = 1'b0;
   logic frame_ready = 1'b0;
   logic [DW-1:0] d_data = '0;
   logic d_ready, frame_valid, drop_pulse;
   logic [FL*DW-1:0] frame_data;
   logic [3:0] state;
   int tests = 0;
   int fails = 0;
   logic [DW-1:0] items[$];
   logic [FL*DW-1:0] sb[$];
   int idle = 0;
   bit exp_drop = 1'b0;

   d_frame_rx #(.FRAME_LEN(FL), .D_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .d_valid(d_valid), .d_data(d_data), .d_ready(d_ready),
      .frame_valid(frame_valid), .frame_data(frame_data), .frame_ready(frame_ready),
      .state(state), .drop_pulse(drop_pulse)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [FL*DW-1:0] pack();
      logic [FL*DW-1:0] f = '0;
      for (int i = FL - 1; i >= 0; i--) f = (f << DW) | (FL*DW)'(items[i]);
      return f;
   endfunction

   function automatic logic [3:0] exp_state();
      return items.size() > 0 ? 4'h1 : sb.size() > 0 ? 4'h2 : 4'h0;
   endfunction

   task automatic cycle(input bit v, input logic [DW-1:0] d, input bit fr);
      bit rdy;
      @(negedge clk);
      d_valid = v;
      d_data = d;
      frame_ready = fr;
      #1;
      rdy = sb.size() == 0 || fr;
      check("d_ready", 32'(d_ready), 32'(rdy));
      check("state", 32'(state), 32'(exp_state()));
      check("frame_valid", 32'(frame_valid), 32'(sb.size() != 0));
      check("drop_pulse", 32'(drop_pulse), 32'(exp_drop));
      exp_drop = 1'b0;
`ifdef D_FRAME_RX_TIMEOUT_EN
      if (items.size() > 0 && idle == TO) begin
         items.delete();
         idle = 0;
         exp_drop = 1'b1;
      end
`endif
      if (v && rdy) begin
         items.push_back(d);
         idle = 0;
         if (items.size() == FL) begin
            sb.push_back(pack());
            items.delete();
         end
      end else if (items.size() > 0) begin
         idle++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      d_valid = 1'b0;
      frame_ready = 1'b0;
      items.delete();
      sb.delete();
      idle = 0;
      exp_drop = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_state", 32'(state), 32'h0);
      check("rst_frame_valid", 32'(frame_valid), 32'h0);
      check("rst_frame_data", 32'(frame_data), 32'h0);
      check("rst_d_ready", 32'(d_ready), 32'h1);
      check("rst_drop", 32'(drop_pulse), 32'h0);
   endtask

   initial forever begin
      @(negedge clk);
      #2;
      if (!rst && frame_valid) begin
         if (sb.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_unexpected: got %0h expected no frame", frame_data);
         end else begin
            check("frame_data", 32'(frame_data), 32'(sb[0]));
            if (frame_ready) void'(sb.pop_front());
         end
      end
   end

   initial begin
      do_reset();
      for (int i = 0; i < FL; i++) cycle(1'b1, DW'(i % 8), 1'b1);
      cycle(1'b0, '0, 1'b1);
      check("frame_const", 32'(frame_data), 32'h08FAC688);
      cycle(1'b0, '0, 1'b1);
      for (int i = 0; i < FL; i++) cycle(1'b1, DW'($urandom), 1'b0);
      for (int i = 0; i < 5; i++) cycle(1'b1, DW'($urandom), 1'b0);
      check("stall_state", 32'(state), 32'h2);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      for (int i = 0; i < 25; i++) cycle(1'b1, DW'($urandom), 1'b1);
      cycle(1'b0, '0, 1'b1);
      check("burst_end_state", 32'(state), 32'h1);
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b1, DW'($urandom), 1'b1);
      do_reset();
      for (int i = 0; i < FL; i++) cycle(1'b1, DW'($urandom), 1'b1);
      cycle(1'b0, '0, 1'b1);
      cycle(1'b0, '0, 1'b1);
      for (int i = 0; i < 3; i++) cycle(1'b1, DW'($urandom), 1'b1);
      for (int i = 0; i < 18; i++) cycle(1'b0, '0, 1'b1);
`ifndef D_FRAME_RX_TIMEOUT_EN
      check("collect_waits", 32'(state), 32'h1);
`endif
      for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom), 1'b1);
      cycle(1'b0, '0, 1'b1);
      do_reset();
      @(negedge clk);
      d_valid = 1'b0;
      force dut.state_q = 4'hB;
      #1;
      release dut.state_q;
      @(posedge clk);
      #1;
      check("illegal_recover", 32'(state), 32'h0);
      check("illegal_d_ready", 32'(d_ready), 32'h1);
      for (int i = 0; i < 1500; i++)
         cycle(bit'($urandom_range(0, 3) != 0), DW'($urandom), bit'($urandom_range(0, 9) < 7));
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1);
      check("drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
